// File: rtl/ym3438_bus_if.sv
// CPU-side write/status interface for the FM core.
// CPU bus writes are edge-detected and parked in address/data holding
// registers. They are then replayed onto the c1 internal cycle grid as
// one-internal-cycle strobes with the matching byte and bank bit. The block
// also keeps the busy counter and returns the registered status byte on reads.
module ym3438_bus_if #(
    parameter int BUSY_CYCLES = 32
) (
    input  logic       MCLK,
    input  logic       rst,
    input  logic       c1,
    input  logic       c2,
    input  logic       cpu_cs,
    input  logic       cpu_wr,
    input  logic       cpu_rd,
    input  logic [1:0] cpu_a,
    input  logic [7:0] cpu_din,
    input  logic       timer_a_flag,
    input  logic       timer_b_flag,
    output logic [7:0] cpu_dout,
    output logic [7:0] data,
    output logic       bank,
    output logic       write_addr_en,
    output logic       write_data_en,
    output logic       busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_DATA
    } state_t;

    localparam logic [5:0] BUSY_LOAD = 6'(BUSY_CYCLES);

    state_t     state;
    state_t     state_nxt;
    logic       wr_prev;
    logic       wr_ev;
    logic       addr_pend;
    logic       data_pend;
    logic       bank_hold;
    logic [7:0] addr_hold;
    logic [7:0] data_hold;
    logic [5:0] busy_cnt;
    logic       issue_addr;
    logic       issue_data;
    logic       unused_c2;

    // The strobe window is defined by c1 alone; c2 always falls inside it.
    assign unused_c2 = c2;

    // A held strobe produces a single event on its first cycle only.
    assign wr_ev = cpu_cs & cpu_wr & ~wr_prev;

    // Issue decision, taken only on c1 edges. After an address issue, a
    // pending data byte goes next; otherwise address has priority over data.
    always_comb begin
        state_nxt  = state;
        issue_addr = 1'b0;
        issue_data = 1'b0;
        if (c1) begin
            state_nxt = S_IDLE;
            if (state != S_ADDR && addr_pend) begin
                state_nxt  = S_ADDR;
                issue_addr = 1'b1;
            end else if (data_pend) begin
                state_nxt  = S_DATA;
                issue_data = 1'b1;
            end
        end
    end

    // Issue state register; the strobes decode directly from it.
    always_ff @(posedge MCLK) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Capture CPU writes. A new event on the same edge as an issue re-arms
    // the pend flag, so the later write is never lost.
    always_ff @(posedge MCLK) begin
        if (rst) begin
            wr_prev   <= 1'b0;
            addr_pend <= 1'b0;
            data_pend <= 1'b0;
            addr_hold <= 8'h00;
            data_hold <= 8'h00;
            bank_hold <= 1'b0;
        end else begin
            wr_prev <= cpu_cs & cpu_wr;
            if (issue_addr) begin
                addr_pend <= 1'b0;
            end
            if (issue_data) begin
                data_pend <= 1'b0;
            end
            if (wr_ev) begin
                if (!cpu_a[0]) begin
                    addr_hold <= cpu_din;
                    bank_hold <= cpu_a[1];
                    addr_pend <= 1'b1;
                end else begin
                    data_hold <= cpu_din;
                    data_pend <= 1'b1;
                end
            end
        end
    end

    // Byte and bank presented to register control; held between issues.
    always_ff @(posedge MCLK) begin
        if (rst) begin
            data <= 8'h00;
            bank <= 1'b0;
        end else if (issue_addr) begin
            data <= addr_hold;
            bank <= bank_hold;
        end else if (issue_data) begin
            data <= data_hold;
        end
    end

    // Busy counter: reloaded on every data issue, counts c1 pulses down to 0.
    always_ff @(posedge MCLK) begin
        if (rst) begin
            busy_cnt <= 6'd0;
        end else if (issue_data) begin
            busy_cnt <= BUSY_LOAD;
        end else if (c1 && busy_cnt != 6'd0) begin
            busy_cnt <= busy_cnt - 6'd1;
        end
    end

    // Registered status byte; zero whenever no read is in progress.
    always_ff @(posedge MCLK) begin
        if (rst) begin
            cpu_dout <= 8'h00;
        end else if (cpu_cs && cpu_rd) begin
            cpu_dout <= {busy, 5'b00000, timer_b_flag, timer_a_flag};
        end else begin
            cpu_dout <= 8'h00;
        end
    end

    assign write_addr_en = (state == S_ADDR);
    assign write_data_en = (state == S_DATA);
    assign busy          = (busy_cnt != 6'd0) | data_pend;

endmodule

// File: tb/tb_ym3438_bus_if.sv
// Testbench for ym3438_bus_if: directed scenarios plus a randomized run
// compared against a transaction-level reference model.
module tb_ym3438_bus_if;

    localparam int BC = 32;

    logic       MCLK = 1'b0;
    logic       rst = 1'b1;
    logic       c1 = 1'b0;
    logic       c2 = 1'b0;
    logic       cpu_cs = 1'b0;
    logic       cpu_wr = 1'b0;
    logic       cpu_rd = 1'b0;
    logic [1:0] cpu_a = 2'b00;
    logic [7:0] cpu_din = 8'h00;
    logic       timer_a_flag = 1'b0;
    logic       timer_b_flag = 1'b0;
    logic [7:0] cpu_dout;
    logic [7:0] data;
    logic       bank;
    logic       write_addr_en;
    logic       write_data_en;
    logic       busy;
    logic [19:0] outs;

    int total = 0;
    int bad   = 0;
    int ph    = 0;

    ym3438_bus_if #(.BUSY_CYCLES(BC)) dut (
        .MCLK         (MCLK),
        .rst          (rst),
        .c1           (c1),
        .c2           (c2),
        .cpu_cs       (cpu_cs),
        .cpu_wr       (cpu_wr),
        .cpu_rd       (cpu_rd),
        .cpu_a        (cpu_a),
        .cpu_din      (cpu_din),
        .timer_a_flag (timer_a_flag),
        .timer_b_flag (timer_b_flag),
        .cpu_dout     (cpu_dout),
        .data         (data),
        .bank         (bank),
        .write_addr_en(write_addr_en),
        .write_data_en(write_data_en),
        .busy         (busy)
    );

    assign outs = {cpu_dout, data, bank, write_addr_en, write_data_en, busy};

    always #5 MCLK = ~MCLK;

    // Internal cycle of 6 MCLK: one c1 pulse, one c2 pulse three clocks later.
    always @(posedge MCLK) begin
        ph <= (ph == 5) ? 0 : ph + 1;
        c1 <= (ph == 5);
        c2 <= (ph == 2);
    end

    // Reference model: one pending slot per kind (last write wins), the kind
    // issued in the current internal cycle, and busy as a c1-count deadline.
    typedef struct {
        logic       prev;
        logic       addr_pend;
        logic       data_pend;
        logic       bank_hold;
        logic       bank_o;
        logic [7:0] addr_hold;
        logic [7:0] data_hold;
        logic [7:0] data_o;
        logic [7:0] dout;
        int         kind;       // 0 none, 1 address, 2 data
        int         c1n;        // c1 pulses seen since reset
        int         busy_until; // busy while c1n below this
    } model_t;

    model_t m;

    function automatic logic m_busy(model_t s);
        return s.data_pend || (s.c1n < s.busy_until);
    endfunction

    function automatic logic [19:0] model_outs(model_t s);
        return {s.dout, s.data_o, s.bank_o, s.kind == 1, s.kind == 2, m_busy(s)};
    endfunction

    function automatic model_t model_step(model_t s);
        model_t n = s;
        logic   ev;
        if (rst) begin
            n.prev = 0; n.addr_pend = 0; n.data_pend = 0; n.bank_hold = 0;
            n.bank_o = 0; n.addr_hold = 0; n.data_hold = 0; n.data_o = 0;
            n.dout = 0; n.kind = 0; n.c1n = 0; n.busy_until = 0;
            return n;
        end
        n.dout = (cpu_cs && cpu_rd) ? {m_busy(s), 5'b00000, timer_b_flag, timer_a_flag} : 8'h00;
        ev     = cpu_cs && cpu_wr && !s.prev;
        n.prev = cpu_cs && cpu_wr;
        if (c1) begin
            n.c1n  = s.c1n + 1;
            n.kind = 0;
            if (s.kind != 1 && s.addr_pend) begin
                n.kind      = 1;
                n.data_o    = s.addr_hold;
                n.bank_o    = s.bank_hold;
                n.addr_pend = 0;
            end else if (s.data_pend) begin
                n.kind       = 2;
                n.data_o     = s.data_hold;
                n.data_pend  = 0;
                n.busy_until = n.c1n + BC;
            end
        end
        if (ev) begin
            if (!cpu_a[0]) begin
                n.addr_hold = cpu_din;
                n.bank_hold = cpu_a[1];
                n.addr_pend = 1;
            end else begin
                n.data_hold = cpu_din;
                n.data_pend = 1;
            end
        end
        return n;
    endfunction

    always @(posedge MCLK) m <= model_step(m);

    // Return at the negedge just after a c1 edge, five MCLKs before the next.
    task automatic align();
        int n = 0;
        @(negedge MCLK);
        while (c1 !== 1'b1 && n < 20) begin
            @(negedge MCLK);
            n++;
        end
        @(negedge MCLK);
    endtask

    task automatic cpu_write(input logic [1:0] a, input logic [7:0] d);
        cpu_cs = 1'b1; cpu_wr = 1'b1; cpu_a = a; cpu_din = d;
        @(negedge MCLK);
        cpu_cs = 1'b0; cpu_wr = 1'b0;
        @(negedge MCLK);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge MCLK);
        total++;
        if (outs !== 20'h0) begin
            bad++; $display("FAIL reset_hold got=%h want=%h", outs, 20'h0);
        end
        rst = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge MCLK);
            total++;
            if (outs !== 20'h0) begin
                bad++; $display("FAIL reset_idle cyc=%0d got=%h want=%h", i, outs, 20'h0);
            end
        end
    endtask

    task automatic test_addr_write();
        int cnt = 0;
        align();
        cpu_write(2'b10, 8'h30);
        for (int i = 0; i < 20; i++) begin
            @(negedge MCLK);
            total++;
            if (write_data_en !== 1'b0) begin
                bad++; $display("FAIL addr_no_data got=%b want=0", write_data_en);
            end
            if (write_addr_en === 1'b1) begin
                cnt++;
                total++;
                if (data !== 8'h30 || bank !== 1'b1) begin
                    bad++; $display("FAIL addr_payload got=%h/%b want=30/1", data, bank);
                end
            end
        end
        total++;
        if (cnt != 6) begin
            bad++; $display("FAIL addr_width got=%0d want=6", cnt);
        end
    endtask

    task automatic test_addr_then_data();
        logic exp_wa, exp_wd, exp_busy;
        align();
        cpu_write(2'b00, 8'h28);
        cpu_cs = 1'b1; cpu_wr = 1'b1; cpu_a = 2'b01; cpu_din = 8'hF1;
        @(negedge MCLK);
        cpu_cs = 1'b0; cpu_wr = 1'b0;
        for (int i = 0; i <= 6 * BC + 12; i++) begin
            exp_wa   = (i >= 3 && i <= 8);
            exp_wd   = (i >= 9 && i <= 14);
            exp_busy = (i <= 6 * BC + 8);
            total++;
            if (write_addr_en !== exp_wa || write_data_en !== exp_wd || busy !== exp_busy) begin
                bad++;
                $display("FAIL ad_seq i=%0d got=%b%b%b want=%b%b%b", i,
                         write_addr_en, write_data_en, busy, exp_wa, exp_wd, exp_busy);
            end
            if (exp_wa) begin
                total++;
                if (data !== 8'h28 || bank !== 1'b0) begin
                    bad++; $display("FAIL ad_addr_byte got=%h/%b want=28/0", data, bank);
                end
            end
            if (exp_wd) begin
                total++;
                if (data !== 8'hF1) begin
                    bad++; $display("FAIL ad_data_byte got=%h want=f1", data);
                end
            end
            @(negedge MCLK);
        end
    endtask

    task automatic test_held_write();
        int cnt = 0;
        align();
        cpu_cs = 1'b1; cpu_wr = 1'b1; cpu_a = 2'b00; cpu_din = 8'h55;
        for (int i = 0; i < 50; i++) begin
            @(negedge MCLK);
            if (i == 19) begin
                cpu_cs = 1'b0; cpu_wr = 1'b0;
            end
            total++;
            if (write_data_en !== 1'b0) begin
                bad++; $display("FAIL held_no_data got=%b want=0", write_data_en);
            end
            if (write_addr_en === 1'b1) begin
                cnt++;
                total++;
                if (data !== 8'h55 || bank !== 1'b0) begin
                    bad++; $display("FAIL held_payload got=%h/%b want=55/0", data, bank);
                end
            end
        end
        total++;
        if (cnt != 6) begin
            bad++; $display("FAIL held_single got=%0d want=6", cnt);
        end
    endtask

    task automatic test_back_to_back();
        int cnt = 0;
        align();
        cpu_write(2'b01, 8'h11);
        cpu_write(2'b01, 8'h22);
        for (int i = 0; i < 30; i++) begin
            @(negedge MCLK);
            total++;
            if (write_addr_en !== 1'b0) begin
                bad++; $display("FAIL b2b_no_addr got=%b want=0", write_addr_en);
            end
            if (write_data_en === 1'b1) begin
                cnt++;
                total++;
                if (data !== 8'h22) begin
                    bad++; $display("FAIL b2b_last_wins got=%h want=22", data);
                end
            end
        end
        total++;
        if (cnt != 6) begin
            bad++; $display("FAIL b2b_width got=%0d want=6", cnt);
        end
    endtask

    task automatic test_status();
        int n = 0;
        timer_a_flag = 1'b1;
        @(negedge MCLK);
        total++;
        if (busy !== 1'b1) begin
            bad++; $display("FAIL st_busy_set got=%b want=1", busy);
        end
        cpu_cs = 1'b1; cpu_rd = 1'b1;
        @(negedge MCLK);
        cpu_cs = 1'b0; cpu_rd = 1'b0;
        total++;
        if (cpu_dout !== 8'h81) begin
            bad++; $display("FAIL st_busy_read got=%h want=81", cpu_dout);
        end
        @(negedge MCLK);
        total++;
        if (cpu_dout !== 8'h00) begin
            bad++; $display("FAIL st_no_read got=%h want=00", cpu_dout);
        end
        while (busy !== 1'b0 && n < 400) begin
            @(negedge MCLK);
            n++;
        end
        total++;
        if (busy !== 1'b0) begin
            bad++; $display("FAIL st_busy_expire got=%b want=0", busy);
        end
        cpu_cs = 1'b1; cpu_rd = 1'b1;
        @(negedge MCLK);
        total++;
        if (cpu_dout !== 8'h01) begin
            bad++; $display("FAIL st_idle_read got=%h want=01", cpu_dout);
        end
        timer_b_flag = 1'b1;
        @(negedge MCLK);
        total++;
        if (cpu_dout !== 8'h03) begin
            bad++; $display("FAIL st_both_flags got=%h want=03", cpu_dout);
        end
        cpu_cs = 1'b0; cpu_rd = 1'b0; timer_a_flag = 1'b0; timer_b_flag = 1'b0;
        @(negedge MCLK);
    endtask

    task automatic test_reset_mid();
        int n = 0;
        align();
        cpu_write(2'b01, 8'h44);
        while (write_data_en !== 1'b1 && n < 20) begin
            @(negedge MCLK);
            n++;
        end
        cpu_cs = 1'b1; cpu_wr = 1'b1; cpu_a = 2'b00; cpu_din = 8'h66;
        @(negedge MCLK);
        cpu_cs = 1'b0; cpu_wr = 1'b0;
        total++;
        if (write_data_en !== 1'b1) begin
            bad++; $display("FAIL rm_strobe_live got=%b want=1", write_data_en);
        end
        rst = 1'b1;
        @(negedge MCLK);
        rst = 1'b0;
        total++;
        if (outs !== 20'h0) begin
            bad++; $display("FAIL rm_drop got=%h want=%h", outs, 20'h0);
        end
        for (int i = 0; i < 60; i++) begin
            @(negedge MCLK);
            total++;
            if (outs !== 20'h0) begin
                bad++; $display("FAIL rm_no_issue cyc=%0d got=%h want=%h", i, outs, 20'h0);
            end
        end
    endtask

    task automatic test_random();
        rst = 1'b1;
        @(negedge MCLK);
        rst = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge MCLK);
            total++;
            if (outs !== model_outs(m)) begin
                bad++; $display("FAIL rand cyc=%0d got=%h want=%h", i, outs, model_outs(m));
            end
            cpu_cs       = ($urandom_range(0, 3) != 0);
            cpu_wr       = ($urandom_range(0, 2) == 0);
            cpu_rd       = ($urandom_range(0, 2) == 0);
            cpu_a        = 2'($urandom_range(0, 3));
            cpu_din      = 8'($urandom);
            timer_a_flag = 1'($urandom);
            timer_b_flag = 1'($urandom);
            rst          = ($urandom_range(0, 299) == 0);
        end
        cpu_cs = 1'b0; cpu_wr = 1'b0; cpu_rd = 1'b0; rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_addr_write();
        test_addr_then_data();
        test_held_write();
        test_back_to_back();
        test_status();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
